spi_slave_fifo: RTL and testbench

Next-generation SPI slave supporting multi-word bursts under a single CS assertion. It has parametrised word width and per-direction FIFO depth. CPOL, CPHA and bit order are latched per frame. Sits between the external SPI pins and an on-chip valid/ready stream pair, with underrun, overflow and partial-word reporting.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_sync_fifo.sv | 50 +++++
 rtl/spi_slave_fifo.sv | 199 +++++++++++++++++++
 tb/tb_spi_slave_fifo.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave with stream FIFOs.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is always on rd_data.
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  output logic                          full,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          empty,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = level_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign rd_data = mem[rd_ptr];
  assign do_pop  = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = wr_en && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/spi_slave_fifo.sv
// SPI slave with multi-word bursts per CS frame, per-frame mode latching and
// valid/ready RX/TX streams buffered by FWFT FIFOs.
module spi_slave_fifo
  import spi_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH    = 8,
  parameter int unsigned           FIFO_DEPTH    = 4,
  parameter logic [DATA_WIDTH-1:0] UNDERRUN_FILL = '0,
  parameter int unsigned           SYNC_STAGES   = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               sclk,
  input  logic                               cs_n,
  input  logic                               mosi,
  output logic                               miso,
  output logic                               miso_oe,
  input  logic                               cpol,
  input  logic                               cpha,
  input  logic                               lsb_first,
  input  logic [DATA_WIDTH-1:0]              tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic [DATA_WIDTH-1:0]              rx_data,
  output logic                               rx_valid,
  input  logic                               rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    tx_level,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    rx_level,
  output logic                               tx_underrun,
  output logic                               rx_overflow,
  output logic                               frame_end,
  output logic                               rx_partial
);

  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
  logic lead_edge, trail_edge, sample_edge, shift_edge;

  state_t state, state_d;
  logic cpol_l, cpha_l, lsb_l, cpol_d, cpha_d, lsb_d;
  logic skip_first, skip_d, load_pending, load_d;
  logic [BW-1:0] bit_cnt, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_in, shift_in_d, shift_out, shift_out_d;
  logic word_load, rx_push, underrun_d, overflow_d, frame_end_d, partial_d;

  logic tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_pop;
  logic [DATA_WIDTH-1:0] tx_head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclk_rise   = sclk_sync[SYNC_STAGES-2] && !sclk_sync[SYNC_STAGES-1];
  assign sclk_fall   = !sclk_sync[SYNC_STAGES-2] && sclk_sync[SYNC_STAGES-1];
  assign cs_fall     = !cs_sync[SYNC_STAGES-2] && cs_sync[SYNC_STAGES-1];
  assign cs_rise     = cs_sync[SYNC_STAGES-2] && !cs_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign lead_edge   = cpol_l ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_l ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_l ? trail_edge : lead_edge;
  assign shift_edge  = cpha_l ? lead_edge : trail_edge;

  always_comb begin
    state_d     = state;
    cpol_d      = cpol_l;
    cpha_d      = cpha_l;
    lsb_d       = lsb_l;
    skip_d      = skip_first;
    load_d      = load_pending;
    bit_cnt_d   = bit_cnt;
    shift_in_d  = shift_in;
    shift_out_d = shift_out;
    word_load   = 1'b0;
    rx_push     = 1'b0;
    frame_end_d = 1'b0;
    partial_d   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          cpol_d    = cpol;
          cpha_d    = cpha;
          lsb_d     = lsb_first;
          bit_cnt_d = '0;
          skip_d    = cpha;
          load_d    = 1'b0;
          word_load = 1'b1;
        end
      end
      ACTIVE: begin
        // CS rise takes priority over any coincident SCLK edge.
        if (cs_rise) begin
          state_d     = IDLE;
          frame_end_d = 1'b1;
          partial_d   = (bit_cnt != '0);
        end else begin
          if (shift_edge) begin
            if (skip_first)        skip_d = 1'b0;
            else if (load_pending) begin
              word_load = 1'b1;
              load_d    = 1'b0;
            end else if (lsb_l)    shift_out_d = shift_out >> 1;
            else                   shift_out_d = shift_out << 1;
          end
          if (sample_edge) begin
            shift_in_d = lsb_l ? {mosi_s, shift_in[DATA_WIDTH-1:1]}
                               : {shift_in[DATA_WIDTH-2:0], mosi_s};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt_d = '0;
              rx_push   = 1'b1;
              load_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (word_load) shift_out_d = tx_empty ? UNDERRUN_FILL : tx_head;
    tx_pop     = word_load && !tx_empty;
    underrun_d = word_load && tx_empty;
    overflow_d = rx_push && rx_full && !rx_pop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cpol_l       <= 1'b0;
      cpha_l       <= 1'b0;
      lsb_l        <= 1'b0;
      skip_first   <= 1'b0;
      load_pending <= 1'b0;
      bit_cnt      <= '0;
      shift_in     <= '0;
      shift_out    <= '0;
      tx_underrun  <= 1'b0;
      rx_overflow  <= 1'b0;
      frame_end    <= 1'b0;
      rx_partial   <= 1'b0;
    end else begin
      state        <= state_d;
      cpol_l       <= cpol_d;
      cpha_l       <= cpha_d;
      lsb_l        <= lsb_d;
      skip_first   <= skip_d;
      load_pending <= load_d;
      bit_cnt      <= bit_cnt_d;
      shift_in     <= shift_in_d;
      shift_out    <= shift_out_d;
      tx_underrun  <= underrun_d;
      rx_overflow  <= overflow_d;
      frame_end    <= frame_end_d;
      rx_partial   <= partial_d;
    end
  end

  assign miso     = lsb_l ? shift_out[0] : shift_out[DATA_WIDTH-1];
  assign miso_oe  = (state == ACTIVE);
  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;

  spi_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (tx_valid && !tx_full),
    .wr_data (tx_data),
    .full    (tx_full),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .empty   (tx_empty),
    .level   (tx_level)
  );

  spi_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (rx_push),
    .wr_data (shift_in_d),
    .full    (rx_full),
    .rd_en   (rx_pop),
    .rd_data (rx_data),
    .empty   (rx_empty),
    .level   (rx_level)
  );

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Scoreboard bench for spi_slave_fifo: directed SPI frames with hand-computed
// expected words; an RX monitor and a pulse monitor run alongside the master.
module tb_spi_slave_fifo;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int HALF  = 10;

  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic tx_valid = 1'b0, rx_ready = 1'b1;
  logic miso, miso_oe, tx_ready, rx_valid;
  logic tx_underrun, rx_overflow, frame_end, rx_partial;
  logic [W-1:0] rx_data;
  logic [2:0] tx_level, rx_level;

  int n_checks = 0, n_fail = 0;
  int cnt_und = 0, cnt_ovf = 0, cnt_fe = 0, cnt_part = 0;
  int base_und = 0, base_ovf = 0, base_fe = 0, base_part = 0;
  logic [W-1:0] rx_exp[$];
  logic [W-1:0] miso_exp[$];
  logic [W-1:0] mo [8];

  spi_slave_fifo #(
    .DATA_WIDTH   (W),
    .FIFO_DEPTH   (DEPTH),
    .UNDERRUN_FILL(8'hFF),
    .SYNC_STAGES  (3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_level(tx_level), .rx_level(rx_level),
    .tx_underrun(tx_underrun), .rx_overflow(rx_overflow),
    .frame_end(frame_end), .rx_partial(rx_partial)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // RX stream monitor and pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_underrun) cnt_und++;
      if (rx_overflow) cnt_ovf++;
      if (frame_end)   cnt_fe++;
      if (rx_partial) begin
        cnt_part++;
        check("partial_with_frame_end", frame_end, 1);
      end
      if (rx_valid && rx_ready) begin
        if (rx_exp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected: got 0x%0h expected nothing", rx_data);
        end else begin
          check("rx_data", rx_data, rx_exp.pop_front());
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input bit p, input bit h, input bit b, input bit last, output bit m);
    if (!h) begin
      mosi = b;
      wait_clk(HALF);
      sclk = ~p;
      m = miso;
      wait_clk(HALF);
      sclk = p;
      if (last) cs_n = 1'b1;
    end else begin
      sclk = ~p;
      mosi = b;
      wait_clk(HALF);
      sclk = p;
      m = miso;
      wait_clk(HALF);
      if (last) cs_n = 1'b1;
    end
  endtask

  task automatic frame(input bit p, input bit h, input bit lsb,
                       input int nw, input int pbits, input bit end_frame);
    logic [W-1:0] got, w;
    bit m;
    int total, bi;
    {cpol, cpha, lsb_first} = {p, h, lsb};
    sclk = p;
    wait_clk(HALF);
    cs_n = 1'b0;
    wait_clk(HALF);
    check("miso_oe_active", miso_oe, 1);
    if (miso_exp.size() > 0)
      check("miso_first_bit", miso, lsb ? miso_exp[0][0] : miso_exp[0][W-1]);
    total = nw * W + pbits;
    got = '0;
    for (int i = 0; i < total; i++) begin
      bi = i % W;
      w  = mo[i / W];
      spi_bit(p, h, lsb ? w[bi] : w[W-1-bi], end_frame && (i == total - 1), m);
      if (i == 0) {cpol, cpha, lsb_first} = ~{p, h, lsb};
      if (lsb) got[bi] = m;
      else     got[W-1-bi] = m;
      if (bi == W - 1) begin
        if (miso_exp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL miso_word: got 0x%0h expected nothing", got);
        end else begin
          check("miso_word", got, miso_exp.pop_front());
        end
      end
    end
    wait_clk(HALF);
  endtask

  task automatic tx_push(input logic [W-1:0] d);
    int t;
    t = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && t < 50) begin
      wait_clk(1);
      t++;
    end
    check("tx_ready", tx_ready, 1);
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (rx_exp.size() != 0 && t < 200) begin
      wait_clk(1);
      t++;
    end
    check(name, rx_exp.size(), 0);
  endtask

  task automatic pulses(input string tag, input int du, input int dov, input int dfe, input int dp);
    check({tag, "_underrun"}, cnt_und - base_und, du);
    check({tag, "_overflow"}, cnt_ovf - base_ovf, dov);
    check({tag, "_frame_end"}, cnt_fe - base_fe, dfe);
    check({tag, "_partial"}, cnt_part - base_part, dp);
    base_und = cnt_und; base_ovf = cnt_ovf; base_fe = cnt_fe; base_part = cnt_part;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_miso"}, miso, 0);
    check({tag, "_miso_oe"}, miso_oe, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_tx_ready"}, tx_ready, 1);
    check({tag, "_tx_level"}, tx_level, 0);
    check({tag, "_rx_level"}, rx_level, 0);
    check({tag, "_pulses"}, {tx_underrun, rx_overflow, frame_end, rx_partial}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    wait_clk(3);
    check_reset("por");
    rst_n = 1'b1;
    wait_clk(5);

    // Mode 0, MSB-first, two-word burst.
    tx_push(8'hA5);
    tx_push(8'h3C);
    check("t1_tx_level", tx_level, 2);
    miso_exp.push_back(8'hA5); miso_exp.push_back(8'h3C);
    rx_exp.push_back(8'h5A);   rx_exp.push_back(8'hC3);
    mo[0] = 8'h5A; mo[1] = 8'hC3;
    frame(1'b0, 1'b0, 1'b0, 2, 0, 1'b1);
    drain("t1_rx_drained");
    pulses("t1", 0, 0, 1, 0);

    // Mode 3, LSB-first, one word.
    tx_push(8'h81);
    miso_exp.push_back(8'h81);
    rx_exp.push_back(8'h01);
    mo[0] = 8'h01;
    frame(1'b1, 1'b1, 1'b1, 1, 0, 1'b1);
    drain("t2_rx_drained");
    pulses("t2", 0, 0, 1, 0);

    // Empty TX FIFO: underrun fill on both loads.
    miso_exp.push_back(8'hFF); miso_exp.push_back(8'hFF);
    rx_exp.push_back(8'h11);   rx_exp.push_back(8'h22);
    mo[0] = 8'h11; mo[1] = 8'h22;
    frame(1'b0, 1'b0, 1'b0, 2, 0, 1'b1);
    drain("t3_rx_drained");
    pulses("t3", 2, 0, 1, 0);

    // RX overflow on the fifth word while the stream is stalled.
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mo[i] = 8'h10 + 8'(i);
      miso_exp.push_back(8'hFF);
    end
    for (int i = 0; i < 4; i++) rx_exp.push_back(8'h10 + 8'(i));
    frame(1'b0, 1'b0, 1'b0, 5, 0, 1'b1);
    check("t4_rx_level_full", rx_level, 4);
    check("t4_rx_head", rx_data, 8'h10);
    pulses("t4", 5, 1, 1, 0);
    rx_ready = 1'b1;
    drain("t4_rx_drained");
    check("t4_rx_level_empty", rx_level, 0);

    // Mode 1, CS lost 3 bits into word 2, then a clean frame.
    tx_push(8'hD2);
    tx_push(8'h4E);
    miso_exp.push_back(8'hD2);
    rx_exp.push_back(8'h6B);
    mo[0] = 8'h6B; mo[1] = 8'hA9;
    frame(1'b0, 1'b1, 1'b0, 1, 3, 1'b1);
    drain("t5_rx_drained");
    pulses("t5", 0, 0, 1, 1);
    check("t5_rx_level", rx_level, 0);
    tx_push(8'h37);
    miso_exp.push_back(8'h37);
    rx_exp.push_back(8'hE4);
    mo[0] = 8'hE4;
    frame(1'b0, 1'b1, 1'b0, 1, 0, 1'b1);
    drain("t5b_rx_drained");
    pulses("t5b", 0, 0, 1, 0);

    // Reset mid-word, then a mode 2 frame.
    tx_push(8'h55);
    mo[0] = 8'hC7;
    frame(1'b0, 1'b0, 1'b0, 0, 3, 1'b0);
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    wait_clk(1);
    check_reset("midrst");
    rst_n = 1'b1;
    wait_clk(HALF);
    pulses("t6rst", 0, 0, 0, 0);
    check("t6_miso_oe_idle", miso_oe, 0);
    tx_push(8'h96);
    miso_exp.push_back(8'h96);
    rx_exp.push_back(8'h96);
    mo[0] = 8'h96;
    frame(1'b1, 1'b0, 1'b0, 1, 0, 1'b1);
    drain("t6_rx_drained");
    pulses("t6", 0, 0, 1, 0);
    check("t6_miso_exp_empty", miso_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
